// File: rtl/centroid_scanner.sv
// centroid_scanner: walks the connected-components table after a frame, divides
// each label's x/y sums by its area with one shared restoring divider, and
// streams one centroid record per non-empty label on a valid/ready port.
module centroid_scanner #(
    parameter int unsigned LOC_W    = 32,
    parameter int unsigned COORD_W  = 16,
    parameter int unsigned ID_W     = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ID_W-1:0]    num_labels,
    output logic [ID_W-1:0]    obj_id,
    input  logic [LOC_W-1:0]   obj_area,
    input  logic [LOC_W-1:0]   obj_x,
    input  logic [LOC_W-1:0]   obj_y,
    output logic               c_valid,
    input  logic               c_ready,
    output logic [ID_W-1:0]    c_id,
    output logic [COORD_W-1:0] c_x,
    output logic [COORD_W-1:0] c_y,
    output logic [LOC_W-1:0]   c_area,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
    localparam int unsigned BIT_W = $clog2(LOC_W);

    typedef enum logic [2:0] {
        StIdle, StWait, StLatch, StDivX, StDivY, StOut, StNext, StDone
    } state_e;

    state_e             state;
    logic [ID_W-1:0]    last;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [LOC_W-1:0]   area_q;
    logic [LOC_W-1:0]   y_q;
    logic [LOC_W-1:0]   rem;
    logic [LOC_W-1:0]   quo;

    logic [LOC_W:0]     rem_sh;
    logic               fits;
    logic [LOC_W-1:0]   rem_nxt;
    logic [LOC_W-1:0]   quo_nxt;
    logic [COORD_W-1:0] coord_sat;
    logic               last_bit;

    // One restoring-divide step: shift in the next numerator bit, subtract if it fits,
    // and saturate the finished quotient to the coordinate width.
    always_comb begin
        rem_sh    = {rem, quo[LOC_W-1]};
        fits      = rem_sh >= {1'b0, area_q};
        rem_nxt   = fits ? LOC_W'(rem_sh - {1'b0, area_q}) : rem_sh[LOC_W-1:0];
        quo_nxt   = {quo[LOC_W-2:0], fits};
        coord_sat = (|quo_nxt[LOC_W-1:COORD_W]) ? '1 : quo_nxt[COORD_W-1:0];
        last_bit  = bit_cnt == BIT_W'(LOC_W - 1);
    end

    // Scan sequencer, divider datapath and registered stream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            last    <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            area_q  <= '0;
            y_q     <= '0;
            rem     <= '0;
            quo     <= '0;
            obj_id  <= '0;
            c_valid <= 1'b0;
            c_id    <= '0;
            c_x     <= '0;
            c_y     <= '0;
            c_area  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    obj_id <= '0;
                    if (start) begin
                        last <= num_labels;
                        busy <= 1'b1;
                        if (num_labels == '0) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            obj_id <= ID_W'(1);
                            cnt    <= CNT_W'(READ_LAT);
                            state  <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= StLatch;
                end
                StLatch: begin
                    area_q <= obj_area;
                    y_q    <= obj_y;
                    if (obj_area == '0) begin
                        // Unused or merged label: nothing to emit.
                        state <= StNext;
                    end else begin
                        rem     <= '0;
                        quo     <= obj_x;
                        bit_cnt <= '0;
                        state   <= StDivX;
                    end
                end
                StDivX: begin
                    rem     <= rem_nxt;
                    quo     <= quo_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        c_x     <= coord_sat;
                        rem     <= '0;
                        quo     <= y_q;
                        bit_cnt <= '0;
                        state   <= StDivY;
                    end
                end
                StDivY: begin
                    rem     <= rem_nxt;
                    quo     <= quo_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        c_y     <= coord_sat;
                        c_id    <= obj_id;
                        c_area  <= area_q;
                        c_valid <= 1'b1;
                        state   <= StOut;
                    end
                end
                StOut: begin
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        state   <= StNext;
                    end
                end
                StNext: begin
                    // Compare before increment so the top label id never wraps.
                    if (obj_id == last) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        obj_id <= obj_id + 1'b1;
                        cnt    <= CNT_W'(READ_LAT);
                        state  <= StWait;
                    end
                end
                StDone: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    obj_id <= '0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
